move_validator_ctrl: RTL and testbench
======================================

# move_validator_ctrl

Sequencer for the board validator's per-piece move checkers (pawn, knight, bishop, rook, queen, king). It accepts one move request at a time from game-play control and runs cheap pre-checks: empty source, wrong side, null move, friendly destination. It then dispatches the request to exactly one piece checker, waits for that checker's done strobe under a timeout, and returns a single registered legal/illegal result with a reason code.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT cycles before forcing a TIMEOUT result; range 4–255.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  move request present.
- req_ready  out  1  controller idle; request accepted when req_valid && req_ready.
- old_x, old_y, new_x, new_y  in  3 each  source and destination squares.
- side_to_move  in  1  0 = white, 1 = black.
- board_in  in  4 × [8][8]  board, indexed [y][x]; upstream holds it stable from accept to resp_valid.
- resp_valid  out  1  one-cycle result strobe.
- resp_legal  out  1  move legal; qualified by resp_valid.
- resp_code  out  3  reason code, see Operation.
- chk_start  out  6  one-hot checker start pulse; bit index = piece kind.
- chk_old_x, chk_old_y, chk_new_x, chk_new_y  out  3 each  operands to the checkers.
- chk_h_delta, chk_v_delta  out  3 each  operands to the checkers.
- chk_piece_type  out  4  operand to the checkers.
- chk_done  in  6  per-checker valid_output.
- chk_valid_move  in  6  per-checker valid_move.

## Operation
- Piece encoding: bit3 = colour (0 white, 1 black); bits[2:0] = kind: 0 pawn, 1 knight, 2 bishop, 3 rook, 4 queen, 5 king. 4'd15 = empty square. Kinds 6 and 7 are invalid, except the value 15.
- Reason codes: 0 OK, 1 EMPTY_SRC, 2 WRONG_SIDE, 3 NULL_MOVE, 4 FRIENDLY_DEST, 5 BAD_MOVE (checker rejected), 6 TIMEOUT, 7 BAD_PIECE.
- State machine: IDLE → PRECHECK → (RESP | DISPATCH) ; DISPATCH → WAIT ; WAIT → RESP ; RESP → IDLE.
- IDLE:
  - req_ready = 1.
  - On accept, register the four coordinates and side_to_move.
  - Compute and register h_delta = |new_x − old_x| and v_delta = |new_y − old_y|, 3-bit unsigned, no wrap.
- PRECHECK: evaluate in priority order; the first hit goes to RESP with legal = 0.
  1. Source equals 15 → EMPTY_SRC.
  2. Source kind is 6 or 7 → BAD_PIECE.
  3. Source colour differs from side_to_move → WRONG_SIDE.
  4. h_delta = 0 and v_delta = 0 → NULL_MOVE.
  5. Destination is non-empty and the same colour as the source → FRIENDLY_DEST.
  6. Otherwise latch the selected kind and go to DISPATCH.
- DISPATCH: drive chk_start[kind] = 1 for exactly one cycle. chk_* operands are valid from DISPATCH through WAIT and are held until the next accept.
- WAIT:
  - A timeout counter increments every cycle.
  - chk_done[kind] = 1 → latch chk_valid_move[kind]. Valid gives OK / legal = 1; invalid gives BAD_MOVE / legal = 0.
  - Counter reaches TIMEOUT_CYCLES with no done → TIMEOUT, legal = 0.
  - done and expiry in the same cycle → done wins.
  - chk_done bits of non-selected checkers are ignored.
- RESP:
  - resp_valid = 1 for one cycle.
  - resp_legal and resp_code are registered and hold their value until the next RESP.
- Captures of enemy pieces, en passant, castling and check detection are out of scope; the checkers or the board block own them.

## Timing
- Reset values: state IDLE, req_ready = 1, resp_valid = 0, resp_legal = 0, resp_code = 0, chk_start = 0, all chk_* operands = 0, timeout counter = 0.
- Reset asserted mid-operation aborts immediately. No resp_valid is produced for the aborted request, and chk_start is forced to 0.
- Pre-check rejection latency: accept edge → resp_valid 2 cycles later (PRECHECK, RESP).
- Dispatched latency: 3 + N cycles from accept, where N = cycles from chk_start to chk_done. The queen checker has N = 2, giving resp_valid 5 cycles after accept.
- req_ready is low from the cycle after accept through RESP. The earliest next accept is the cycle after resp_valid.
- req_valid while busy is ignored; no queueing.
- chk_done arriving in DISPATCH (the same cycle as start) is not sampled; sampling begins in WAIT.

## Structure
- Shared package chess_pkg:
  - piece_kind_t enum.
  - EMPTY_SQ = 4'd15.
  - move_result_t enum (the reason codes).
  - N_CHECKERS = 6.
  - Board square type logic [3:0].
- Natural sub-module: move_precheck. It is purely combinational: inputs are the registered request and board_in; outputs are reject, reason code and selected kind.
- Everything else (FSM, delta calculation, timeout counter, operand registers) stays in move_validator_ctrl.

## Test plan
- White queen at (3,0), empty path, request to (3,5), side 0; queen model done after 2 cycles with valid = 1 → resp_valid 5 cycles after accept, legal = 1, code 0, exactly one chk_start[4] pulse.
- Request from empty square (0,4) → resp_valid 2 cycles after accept, legal = 0, code 1, no chk_start activity.
- Black rook at (0,7), side_to_move 0 → code 2. Separately, white knight (1,0) → (3,1) onto a white pawn → code 4.
- old equals new at (4,4) holding a white king → code 3. Separately, source value 4'b0110 → code 7.
- Bishop checker model never asserts done, TIMEOUT_CYCLES = 16 → resp_valid with code 6 after 16 WAIT cycles; a later request completes normally.
- Assert reset_n low during WAIT → no resp_valid; after release req_ready = 1 and a fresh request completes with correct latency.

Source files
------------

// File: rtl/chess_pkg.sv
`default_nettype none
// ============================================================================
// Package  : chess_pkg
// Purpose  : Shared types for the board validator: square encoding, piece
//            kinds, move result (reason) codes and checker count.
// Revision : 1.0 - initial release
// ============================================================================
package chess_pkg;

  // Board square: bit3 = colour (0 white, 1 black), bits[2:0] = piece kind.
  typedef logic [3:0] square_t;

  localparam square_t EMPTY_SQ   = 4'd15;
  localparam int      N_CHECKERS = 6;

  typedef enum logic [2:0] {
    PK_PAWN   = 3'd0,
    PK_KNIGHT = 3'd1,
    PK_BISHOP = 3'd2,
    PK_ROOK   = 3'd3,
    PK_QUEEN  = 3'd4,
    PK_KING   = 3'd5
  } piece_kind_t;

  typedef enum logic [2:0] {
    RES_OK            = 3'd0,
    RES_EMPTY_SRC     = 3'd1,
    RES_WRONG_SIDE    = 3'd2,
    RES_NULL_MOVE     = 3'd3,
    RES_FRIENDLY_DEST = 3'd4,
    RES_BAD_MOVE      = 3'd5,
    RES_TIMEOUT       = 3'd6,
    RES_BAD_PIECE     = 3'd7
  } move_result_t;

endpackage : chess_pkg
`default_nettype wire

// File: rtl/move_validator_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : move_validator_ctrl_if
// Purpose   : Request/response handshake from game-play control plus the
//             operand/strobe bus towards the six per-piece move checkers.
// Modports  : slave  - the controller (move_validator_ctrl)
//             master - the environment (game control, board, checkers)
// Revision  : 1.0 - initial release
// ============================================================================
interface move_validator_ctrl_if;
  import chess_pkg::*;

  // Request side
  logic                   req_valid;
  logic                   req_ready;
  logic [2:0]             old_x;
  logic [2:0]             old_y;
  logic [2:0]             new_x;
  logic [2:0]             new_y;
  logic                   side_to_move;
  square_t [7:0][7:0]     board_in;       // indexed [y][x]

  // Response side
  logic                   resp_valid;
  logic                   resp_legal;
  logic [2:0]             resp_code;

  // Checker side
  logic [N_CHECKERS-1:0]  chk_start;
  logic [2:0]             chk_old_x;
  logic [2:0]             chk_old_y;
  logic [2:0]             chk_new_x;
  logic [2:0]             chk_new_y;
  logic [2:0]             chk_h_delta;
  logic [2:0]             chk_v_delta;
  logic [3:0]             chk_piece_type;
  logic [N_CHECKERS-1:0]  chk_done;
  logic [N_CHECKERS-1:0]  chk_valid_move;

  modport slave (
    input  req_valid, old_x, old_y, new_x, new_y, side_to_move, board_in,
    input  chk_done, chk_valid_move,
    output req_ready, resp_valid, resp_legal, resp_code,
    output chk_start, chk_old_x, chk_old_y, chk_new_x, chk_new_y,
    output chk_h_delta, chk_v_delta, chk_piece_type
  );

  modport master (
    output req_valid, old_x, old_y, new_x, new_y, side_to_move, board_in,
    output chk_done, chk_valid_move,
    input  req_ready, resp_valid, resp_legal, resp_code,
    input  chk_start, chk_old_x, chk_old_y, chk_new_x, chk_new_y,
    input  chk_h_delta, chk_v_delta, chk_piece_type
  );

endinterface : move_validator_ctrl_if
`default_nettype wire

// File: rtl/move_precheck.sv
`default_nettype none
// ============================================================================
// Module   : move_precheck
// Purpose  : Combinational cheap pre-checks on a registered move request.
//            Rejections are reported in priority order; when nothing hits,
//            kind_o names the checker to dispatch to.
// Ports    : board_i            board, [y][x]
//            old/new_x/y_i      registered source / destination squares
//            side_i             side to move (0 white, 1 black)
//            h/v_delta_i        registered absolute deltas
//            reject_o, code_o   rejection flag and reason code
//            kind_o             source piece kind
// Revision : 1.0 - initial release
// ============================================================================
module move_precheck
  import chess_pkg::*;
(
  input  square_t [7:0][7:0] board_i,
  input  logic [2:0]         old_x_i,
  input  logic [2:0]         old_y_i,
  input  logic [2:0]         new_x_i,
  input  logic [2:0]         new_y_i,
  input  logic               side_i,
  input  logic [2:0]         h_delta_i,
  input  logic [2:0]         v_delta_i,
  output logic               reject_o,
  output move_result_t       code_o,
  output logic [2:0]         kind_o
);

  square_t src;
  square_t dst;

  always_comb begin
    src      = board_i[old_y_i][old_x_i];
    dst      = board_i[new_y_i][new_x_i];
    kind_o   = src[2:0];
    reject_o = 1'b1;
    code_o   = RES_OK;
    if (src == EMPTY_SQ) begin
      code_o = RES_EMPTY_SRC;
    end else if (src[2:0] > PK_KING) begin
      // Kinds 6/7 are undefined; 15 was already caught as empty above.
      code_o = RES_BAD_PIECE;
    end else if (src[3] != side_i) begin
      code_o = RES_WRONG_SIDE;
    end else if ((h_delta_i == 3'd0) && (v_delta_i == 3'd0)) begin
      code_o = RES_NULL_MOVE;
    end else if ((dst != EMPTY_SQ) && (dst[3] == src[3])) begin
      code_o = RES_FRIENDLY_DEST;
    end else begin
      reject_o = 1'b0;
    end
  end

endmodule : move_precheck
`default_nettype wire

// File: rtl/move_validator_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : move_validator_ctrl
// Purpose  : Accepts one move request, runs pre-checks, dispatches to exactly
//            one piece checker, waits for its done under a timeout and
//            returns a registered legal/illegal result with reason code.
// Ports    : clk      system clock (rising edge)
//            reset_n  asynchronous active-low reset
//            bus      move_validator_ctrl_if.slave (request, response,
//                     checker operands / strobes)
// Revision : 1.0 - initial release
// ============================================================================
module move_validator_ctrl
  import chess_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16   // 4..255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  move_validator_ctrl_if.slave bus
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRECHECK = 3'd1,
    S_DISPATCH = 3'd2,
    S_WAIT     = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t                state_q;
  logic [2:0]            old_x_q, old_y_q, new_x_q, new_y_q;
  logic                  side_q;
  logic [2:0]            h_delta_q, v_delta_q;
  logic [2:0]            h_delta_d, v_delta_d;
  logic [2:0]            kind_q;
  square_t               piece_q;
  logic [7:0]            timer_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  resp_legal_q;
  move_result_t          resp_code_q;
  logic [N_CHECKERS-1:0] chk_start_q;

  logic                  pc_reject;
  move_result_t          pc_code;
  logic [2:0]            pc_kind;

  // Absolute deltas of the incoming request; captured on accept.
  always_comb begin
    h_delta_d = (bus.new_x >= bus.old_x) ? (bus.new_x - bus.old_x) : (bus.old_x - bus.new_x);
    v_delta_d = (bus.new_y >= bus.old_y) ? (bus.new_y - bus.old_y) : (bus.old_y - bus.new_y);
  end

  move_precheck u_precheck (
    .board_i   (bus.board_in),
    .old_x_i   (old_x_q),
    .old_y_i   (old_y_q),
    .new_x_i   (new_x_q),
    .new_y_i   (new_y_q),
    .side_i    (side_q),
    .h_delta_i (h_delta_q),
    .v_delta_i (v_delta_q),
    .reject_o  (pc_reject),
    .code_o    (pc_code),
    .kind_o    (pc_kind)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      old_x_q      <= '0;
      old_y_q      <= '0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      side_q       <= 1'b0;
      h_delta_q    <= '0;
      v_delta_q    <= '0;
      kind_q       <= '0;
      piece_q      <= '0;
      timer_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_legal_q <= 1'b0;
      resp_code_q  <= RES_OK;
      chk_start_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            old_x_q     <= bus.old_x;
            old_y_q     <= bus.old_y;
            new_x_q     <= bus.new_x;
            new_y_q     <= bus.new_y;
            side_q      <= bus.side_to_move;
            h_delta_q   <= h_delta_d;
            v_delta_q   <= v_delta_d;
            req_ready_q <= 1'b0;
            state_q     <= S_PRECHECK;
          end
        end
        S_PRECHECK: begin
          if (pc_reject) begin
            resp_valid_q <= 1'b1;
            resp_legal_q <= 1'b0;
            resp_code_q  <= pc_code;
            state_q      <= S_RESP;
          end else begin
            kind_q      <= pc_kind;
            piece_q     <= bus.board_in[old_y_q][old_x_q];
            chk_start_q <= 6'b000001 << pc_kind;
            timer_q     <= '0;
            state_q     <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          chk_start_q <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          // Done is tested first so it wins over a coincident expiry.
          if (bus.chk_done[kind_q]) begin
            resp_valid_q <= 1'b1;
            resp_legal_q <= bus.chk_valid_move[kind_q];
            resp_code_q  <= bus.chk_valid_move[kind_q] ? RES_OK : RES_BAD_MOVE;
            state_q      <= S_RESP;
          end else if (timer_q == TIMEOUT_LAST) begin
            resp_valid_q <= 1'b1;
            resp_legal_q <= 1'b0;
            resp_code_q  <= RES_TIMEOUT;
            state_q      <= S_RESP;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          chk_start_q  <= '0;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  // Operands come straight from the request registers, so they are stable
  // from dispatch until the next accept.
  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_legal     = resp_legal_q;
  assign bus.resp_code      = resp_code_q;
  assign bus.chk_start      = chk_start_q;
  assign bus.chk_old_x      = old_x_q;
  assign bus.chk_old_y      = old_y_q;
  assign bus.chk_new_x      = new_x_q;
  assign bus.chk_new_y      = new_y_q;
  assign bus.chk_h_delta    = h_delta_q;
  assign bus.chk_v_delta    = v_delta_q;
  assign bus.chk_piece_type = piece_q;

endmodule : move_validator_ctrl
`default_nettype wire

// File: tb/tb_move_validator_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_validator_ctrl
// Purpose  : Self-checking bench for move_validator_ctrl with simple
//            latency-programmable checker models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_validator_ctrl;
  import chess_pkg::*;

  logic clk;
  logic reset_n;

  move_validator_ctrl_if bus ();

  move_validator_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker models ----------------
  int         lat_cfg [6];   // 0 = never done
  logic [5:0] vld_cfg;
  logic [5:0] extra_done;    // spurious done on non-selected checkers
  int         rem     [6];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 6; k++) rem[k] <= 0;
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (bus.chk_start[k])  rem[k] <= lat_cfg[k];
        else if (rem[k] != 0)  rem[k] <= rem[k] - 1;
      end
    end
  end

  always_comb begin
    bus.chk_done       = extra_done;
    bus.chk_valid_move = vld_cfg;
    for (int k = 0; k < 6; k++) begin
      if (rem[k] == 1) bus.chk_done[k] = 1'b1;
    end
  end

  // chk_start activity monitor (cumulative cycles high per bit)
  int start_cnt [6];
  int start_total;
  initial begin
    for (int k = 0; k < 6; k++) start_cnt[k] = 0;
    start_total = 0;
  end
  always @(posedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (bus.chk_start[k]) begin
        start_cnt[k] = start_cnt[k] + 1;
        start_total  = start_total + 1;
      end
    end
  end

  // ---------------- scoreboard / checking ----------------
  typedef struct {
    logic       legal;
    logic [2:0] code;
    int         lat;
  } exp_t;
  exp_t sb [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_board();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        bus.board_in[y][x] = EMPTY_SQ;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) break;
    end
    check("ready_before_req", bus.req_ready, 1);
  endtask

  // Issue one request, then check response timing/values and chk_start use.
  task automatic do_req(input string tag,
                        input logic [2:0] ox, input logic [2:0] oy,
                        input logic [2:0] nx, input logic [2:0] ny,
                        input logic side, input logic exp_legal,
                        input logic [2:0] exp_code, input int exp_lat,
                        input int exp_kind);
    exp_t e;
    exp_t got_e;
    int   tot0;
    int   k0;
    int   lat;
    bit   seen;
    wait_ready();
    tot0 = start_total;
    k0   = (exp_kind >= 0) ? start_cnt[exp_kind] : 0;
    bus.old_x = ox; bus.old_y = oy; bus.new_x = nx; bus.new_y = ny;
    bus.side_to_move = side;
    bus.req_valid = 1'b1;
    @(posedge clk);                      // accept edge
    e.legal = exp_legal; e.code = exp_code; e.lat = exp_lat;
    sb.push_back(e);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_valid = 1'b0;
        check({tag, "_ready_low"}, bus.req_ready, 0);
      end
      if (bus.resp_valid) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
    check({tag, "_resp_seen"}, seen, 1);
    if (seen) begin
      got_e = sb.pop_front();
      check({tag, "_legal"},   bus.resp_legal, got_e.legal);
      check({tag, "_code"},    bus.resp_code,  got_e.code);
      check({tag, "_latency"}, lat,            got_e.lat);
      @(negedge clk);
      check({tag, "_one_cycle"}, bus.resp_valid, 0);
      check({tag, "_code_hold"}, bus.resp_code,  got_e.code);
    end else begin
      sb.delete();
    end
    check({tag, "_start_total"}, start_total - tot0, (exp_kind >= 0) ? 1 : 0);
    if (exp_kind >= 0)
      check({tag, "_start_kind"}, start_cnt[exp_kind] - k0, 1);
  endtask

  initial begin
    int rv_seen;
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.old_x = '0; bus.old_y = '0; bus.new_x = '0; bus.new_y = '0;
    bus.side_to_move = 1'b0;
    extra_done = '0;
    vld_cfg = 6'b111111;
    for (int k = 0; k < 6; k++) lat_cfg[k] = 1;
    lat_cfg[4] = 2;
    clear_board();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready",  bus.req_ready,      1);
    check("rst_resp_valid", bus.resp_valid,     0);
    check("rst_resp_legal", bus.resp_legal,     0);
    check("rst_resp_code",  bus.resp_code,      0);
    check("rst_chk_start",  bus.chk_start,      0);
    check("rst_chk_old_x",  bus.chk_old_x,      0);
    check("rst_chk_vdelta", bus.chk_v_delta,    0);
    check("rst_chk_piece",  bus.chk_piece_type, 0);
    reset_n = 1'b1;

    // White queen (3,0)->(3,5); a spurious rook done must be ignored
    clear_board();
    bus.board_in[0][3] = 4'b0100;
    extra_done = 6'b001000;
    do_req("queen", 3'd3, 3'd0, 3'd3, 3'd5, 1'b0, 1'b1, 3'd0, 5, 4);
    extra_done = '0;
    check("queen_hdelta", bus.chk_h_delta,    0);
    check("queen_vdelta", bus.chk_v_delta,    5);
    check("queen_piece",  bus.chk_piece_type, 4);
    check("queen_old_x",  bus.chk_old_x,      3);

    // Empty source
    clear_board();
    do_req("empty", 3'd0, 3'd4, 3'd0, 3'd5, 1'b0, 1'b0, 3'd1, 2, -1);

    // Black rook moved by white
    bus.board_in[7][0] = 4'b1011;
    do_req("wrongside", 3'd0, 3'd7, 3'd0, 3'd5, 1'b0, 1'b0, 3'd2, 2, -1);

    // White knight onto white pawn
    clear_board();
    bus.board_in[0][1] = 4'b0001;
    bus.board_in[1][3] = 4'b0000;
    do_req("friendly", 3'd1, 3'd0, 3'd3, 3'd1, 1'b0, 1'b0, 3'd4, 2, -1);

    // Null move with a white king
    clear_board();
    bus.board_in[4][4] = 4'b0101;
    do_req("nullmove", 3'd4, 3'd4, 3'd4, 3'd4, 1'b0, 1'b0, 3'd3, 2, -1);

    // Undefined piece kind
    clear_board();
    bus.board_in[2][2] = 4'b0110;
    do_req("badpiece", 3'd2, 3'd2, 3'd2, 3'd3, 1'b0, 1'b0, 3'd7, 2, -1);

    // White rook, checker rejects after 3 cycles -> BAD_MOVE
    clear_board();
    bus.board_in[0][0] = 4'b0011;
    lat_cfg[3] = 3; vld_cfg[3] = 1'b0;
    do_req("badmove", 3'd0, 3'd0, 3'd0, 3'd6, 1'b0, 1'b0, 3'd5, 6, 3);

    // Bishop done in the last WAIT cycle: done wins over expiry
    clear_board();
    bus.board_in[0][2] = 4'b0010;
    lat_cfg[2] = 16;
    do_req("done_at_expiry", 3'd2, 3'd0, 3'd5, 3'd3, 1'b0, 1'b1, 3'd0, 19, 2);

    // Bishop never done -> TIMEOUT after 16 WAIT cycles
    lat_cfg[2] = 0;
    do_req("timeout", 3'd2, 3'd0, 3'd5, 3'd3, 1'b0, 1'b0, 3'd6, 19, 2);

    // Later request completes normally (black queen, side 1)
    clear_board();
    bus.board_in[7][3] = 4'b1100;
    do_req("after_timeout", 3'd3, 3'd7, 3'd0, 3'd4, 1'b1, 1'b1, 3'd0, 5, 4);

    // Reset asserted during WAIT aborts the request
    clear_board();
    bus.board_in[0][2] = 4'b0010;
    wait_ready();
    bus.old_x = 3'd2; bus.old_y = 3'd0; bus.new_x = 3'd4; bus.new_y = 3'd2;
    bus.side_to_move = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);           // now in WAIT
    reset_n = 1'b0;
    #1;
    check("abort_chk_start",  bus.chk_start,  0);
    check("abort_resp_valid", bus.resp_valid, 0);
    check("abort_req_ready",  bus.req_ready,  1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rv_seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.resp_valid) rv_seen++;
    end
    check("abort_no_resp",   rv_seen,       0);
    check("abort_ready_rel", bus.req_ready, 1);

    // Fresh request after the abort
    clear_board();
    bus.board_in[0][3] = 4'b0100;
    do_req("after_reset", 3'd3, 3'd0, 3'd7, 3'd4, 1'b0, 1'b1, 3'd0, 5, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_move_validator_ctrl
`default_nettype wire
